// File: rtl/switch_debounce.sv
// Per-bit switch debouncer: two-flop synchronizer, shared sample prescaler, and a per-bit
// counter of consecutive differing samples. Produces registered rise/fall pulses.
module switch_debounce #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned TICK_DIV     = 10000,
    parameter int unsigned STABLE_TICKS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             tick
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CW = $clog2(STABLE_TICKS + 1);
    localparam logic [PW-1:0] PresMax = PW'(TICK_DIV - 1);

    logic [WIDTH-1:0]         sync1_q, sync2_q;
    logic [PW-1:0]            presc_q, presc_d;
    logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]         out_q, out_d;
    logic [WIDTH-1:0]         rise_q, rise_d;
    logic [WIDTH-1:0]         fall_q, fall_d;
    logic                     tick_w;

    assign tick_w = ena && (presc_q == PresMax);

    always_comb begin
        presc_d = presc_q;
        if (ena) begin
            presc_d = (presc_q == PresMax) ? '0 : presc_q + PW'(1);
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        out_d  = out_q;
        rise_d = '0;
        fall_d = '0;
        if (tick_w) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (sync2_q[i] == out_q[i]) begin
                    // An agreeing sample cancels any pending change.
                    cnt_d[i] = '0;
                end else if (32'(cnt_q[i]) + 32'd1 >= STABLE_TICKS) begin
                    cnt_d[i]  = '0;
                    out_d[i]  = sync2_q[i];
                    rise_d[i] = sync2_q[i];
                    fall_d[i] = ~sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            presc_q <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
        end else begin
            sync1_q <= sw_in;
            sync2_q <= sync1_q;
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign sw_out = out_q;
    assign rise   = rise_q;
    assign fall   = fall_q;
    assign tick   = tick_w;

endmodule

// File: doc/switch_debounce.md
SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of switch bits.
REQ-002 The block SHALL have parameter TICK_DIV, default 10000, giving clock cycles per sample tick; it SHALL be at least 1.
REQ-003 The block SHALL have parameter STABLE_TICKS, default 4, giving the consecutive differing samples needed to accept a change; it SHALL be at least 1.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state is on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port ena, input, 1 bit: design enable; when high, sampling advances.
REQ-007 The block SHALL have port sw_in, input, WIDTH bits: raw, asynchronous switch inputs.
REQ-008 The block SHALL have port sw_out, output, WIDTH bits: registered debounced switch levels, fed to the seven-segment stage.
REQ-009 The block SHALL have port rise, output, WIDTH bits: registered one-cycle pulse per bit on an accepted 0->1 change.
REQ-010 The block SHALL have port fall, output, WIDTH bits: registered one-cycle pulse per bit on an accepted 1->0 change.
REQ-011 The block SHALL have port tick, output, 1 bit: high in each cycle in which a sample is taken.

Function
REQ-012 Each sw_in bit SHALL pass through a two-flop synchronizer (sync); sync SHALL run regardless of ena.
REQ-013 The prescaler SHALL count 0..TICK_DIV-1 while ena=1, wrap to 0, and hold its value while ena=0.
REQ-014 tick SHALL equal ena AND (prescaler == TICK_DIV-1); with TICK_DIV=1, tick SHALL equal ena.
REQ-015 Each bit SHALL have a counter cnt[i] of width clog2(STABLE_TICKS+1); cnt[i] SHALL change only in tick cycles.
REQ-016 On tick with sync[i]==sw_out[i], cnt[i] SHALL be cleared to 0, so any agreeing sample discards a pending change.
REQ-017 On tick with sync[i]!=sw_out[i] and cnt[i]+1 < STABLE_TICKS, cnt[i] SHALL increment.
REQ-018 On tick with sync[i]!=sw_out[i] and cnt[i]+1 == STABLE_TICKS, the block SHALL accept the change:
- sw_out[i] takes sync[i] at that clock edge.
- cnt[i] is cleared to 0.
REQ-019 rise[i] (or fall[i] for a 1->0 change) SHALL be high for exactly the first cycle in which sw_out[i] shows the new value, and low otherwise.
REQ-020 rise[i] and fall[i] SHALL never be high together; several bits MAY pulse in the same cycle.
REQ-021 Input activity between ticks SHALL be invisible; only tick-cycle samples of sync count.
REQ-022 While ena=0, cnt, sw_out and the prescaler SHALL hold, and rise, fall and tick SHALL be 0.
REQ-023 For a clean step on sw_in, sw_out SHALL update between (STABLE_TICKS-1)*TICK_DIV+3 and STABLE_TICKS*TICK_DIV+3 cycles after the step, with ena held high.

Reset
REQ-024 While rst_n=0, the following SHALL be 0 immediately, independent of clk: sync flops, prescaler, all cnt[i], sw_out, rise, fall and tick.
REQ-025 Reset asserted mid-count SHALL discard pending changes; after release the prescaler SHALL restart from 0.
REQ-026 After reset release, sw_in bits that are already 1 SHALL be accepted through the normal debounce path and produce rise pulses.

Verification (TICK_DIV=4, STABLE_TICKS=3, ena=1 unless stated)
REQ-027 Step: sw_in 0x00->0x01 held -> sw_out=0x01 within 11..15 cycles; rise=0x01 for exactly 1 cycle; fall stays 0.
REQ-028 Glitch: sw_in bit1 high for 2 ticks, then low -> sw_out, rise and fall stay 0x00.
REQ-029 Release: sw_out=0x01, then sw_in -> 0x00 held -> sw_out=0x00; fall=0x01 for 1 cycle, aligned with the sw_out change.
REQ-030 Multi-bit: sw_in 0x00->0xA5 -> sw_out=0xA5 and rise=0xA5 in the same cycle.
REQ-031 Enable: ena=0 for 20 cycles mid-count with sw_in changed -> no tick, outputs frozen; after ena=1 the count resumes from its held value, not from 0.
REQ-032 Reset: sw_out=0xFF, pull rst_n low between clock edges -> all outputs 0 before the next edge; after release with sw_in=0xFF -> rise=0xFF within 15 cycles.
